mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access/writeback stage placed directly downstream of the execute stage.
- Consumes the executed instruction byte, the ALU result and the store data.
- Performs data-memory loads and stores against an internal byte-wide RAM.
- Produces a registered writeback packet for the register file, a jump redirect and a sticky halt flag, with valid/ready flow control on both sides.

Parameters:
- DEPTH, 256, number of data-memory bytes. Address is alu_result modulo DEPTH; must be a power of two, at most 256.
- MEM_LAT, 2, cycles a load or store occupies the RAM before completion; legal range 1–7.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  execute-side packet valid
- in_ready  out  1  stage can accept a packet this cycle
- instr  in  8  instruction byte for the packet
- alu_result  in  8  ALU result or effective address
- write_data  in  8  store data (ST only)
- pc_alu  in  8  jump target from execute (J-type only)
- out_valid  out  1  writeback packet valid
- out_ready  in  1  downstream accepts packet
- wb_en  out  1  register write required
- wb_reg  out  2  destination register
- wb_data  out  8  value to write
- redirect_valid  out  1  jump taken; qualified by out_valid
- redirect_pc  out  8  jump target
- halted  out  1  sticky; HALT has retired

Behaviour:
Reset
- Async, active-high. All outputs go to 0 except in_ready, which is 1.
- State returns to IDLE; any in-flight packet is dropped.
- Memory contents are unchanged (see Optional Feature).

Decode (from the latched instr)
- op = [7:6], sub = [5:4], rt = [3:2].

Packet handling by opcode
- op=00 (R-type): wb_en=1, wb_reg=rt, wb_data=alu_result.
- op=01, sub=00 (ADDI): wb_en=1, wb_reg=rt, wb_data=alu_result.
- op=01, sub=11 (CMP): wb_en=1, wb_reg=rt, wb_data=alu_result.
- op=01, sub=01 (LD): wb_en=1, wb_reg=rt, wb_data=mem[addr] read at completion.
- op=01, sub=10 (ST): mem[addr] <= write_data at completion; wb_en=0.
- op=10 (J-type): wb_en=0, redirect_valid=1, redirect_pc=pc_alu.
- op=11 (HALT): wb_en=0; halted sets to 1 when the packet is accepted downstream and stays 1 until rst.

State machine (IDLE, MEM, OUT)
- IDLE: in_ready=1. On in_valid, capture instr, alu_result, write_data and pc_alu.
  - LD/ST go to MEM with the wait counter set to MEM_LAT-1.
  - All other packets go to OUT.
- MEM: in_ready=0. The counter decrements each cycle. When the counter is 0, perform the RAM access (ST write or LD capture into the wb_data register) and go to OUT next cycle.
  - Latency from acceptance to out_valid is MEM_LAT+1 cycles for LD/ST and 1 cycle for all others.
- OUT: out_valid=1. Outputs are held stable while out_ready=0.
  - On out_ready=1 the packet retires.
  - If in_valid is also high in the same cycle, the new packet is captured (in_ready=1 in OUT only while out_ready=1): back-to-back ALU ops sustain 1 packet per cycle.
  - Otherwise return to IDLE.
- After halted=1, in_ready is forced to 0 and no further packets are accepted.

Arithmetic / address rules
- addr = alu_result[$clog2(DEPTH)-1:0]; upper bits are ignored (address wraps).
- No arithmetic is performed in this stage.

Boundary conditions
- ST followed by LD to the same address: the LD observes the stored value, since accesses are strictly in order.
- rst asserted during MEM: an uncommitted ST is not written; a ST whose write edge coincides with rst assertion is also not written.
- out_ready held low indefinitely: the stage stalls and no packet is lost.

Optional Feature:
- Macro: MEM_RESET_CLEAR_EN.
- Defined: rst clears every memory byte to 0x00, so a LD of a never-written address returns 0x00.
- Not defined: memory has no reset; contents survive rst, and unwritten locations are X in simulation.

Test Plan:
- ADD packet (instr=0x04, alu_result=0x2A), out_ready=1 → next cycle out_valid=1, wb_en=1, wb_reg=1, wb_data=0x2A, redirect_valid=0.
- ST (instr=0x68, alu_result=0x10, write_data=0x5C) then LD (instr=0x5C, alu_result=0x10), MEM_LAT=2 → LD retires with wb_reg=3, wb_data=0x5C; ST retires with wb_en=0; each out_valid appears 3 cycles after acceptance.
- Jump packet (instr=0x85, pc_alu=0x05) → out_valid=1, redirect_valid=1, redirect_pc=0x05, wb_en=0.
- out_ready=0 for 4 cycles with an ADDI pending (wb_data=0x07) → outputs constant and in_ready=0; upon release the packet retires once and back-to-back accept resumes.
- HALT (instr=0xC0) accepted → halted=1 after retire and in_ready stays 0 despite in_valid=1; rst → halted=0, in_ready=1.
- With MEM_RESET_CLEAR_EN: ST 0xFF to addr 0x20, pulse rst, LD addr 0x20 → wb_data=0x00. Without the macro, the same sequence returns 0xFF.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access/writeback stage with byte RAM, jump redirect and sticky halt.
// Define MEM_RESET_CLEAR_EN to have rst clear every memory byte to 0x00.
module mem_stage #(
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] instr,
    input  logic [7:0] alu_result,
    input  logic [7:0] write_data,
    input  logic [7:0] pc_alu,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       wb_en,
    output logic [1:0] wb_reg,
    output logic [7:0] wb_data,
    output logic       redirect_valid,
    output logic [7:0] redirect_pc,
    output logic       halted
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, MEM, OUT} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      instr_q, wb_q, wdata_q, pc_q;
    logic            halted_q;
    logic [7:0]      mem_q [DEPTH];
    logic [1:0]      op, sub;
    logic [AW-1:0]   addr;
    logic            accept, retire, mem_done, mem_we, in_mem;

    assign op       = instr_q[7:6];
    assign sub      = instr_q[5:4];
    assign addr     = wb_q[AW-1:0];
    assign in_mem   = instr[7:6] == 2'b01 && (instr[5:4] == 2'b01 || instr[5:4] == 2'b10);
    assign mem_done = state_q == MEM && cnt_q == '0;
    assign mem_we   = mem_done && op == 2'b01 && sub == 2'b10 && !rst;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        // A retiring HALT must not let a younger packet slip in behind it.
        in_ready       = !halted_q && (state_q == IDLE || (state_q == OUT && out_ready && op != 2'b11));
        accept         = in_valid && in_ready;
        out_valid      = state_q == OUT;
        retire         = out_valid && out_ready;
        wb_en          = out_valid && (op == 2'b00 || (op == 2'b01 && sub != 2'b10));
        wb_reg         = instr_q[3:2];
        wb_data        = wb_q;
        redirect_valid = out_valid && op == 2'b10;
        redirect_pc    = pc_q;
        halted         = halted_q;
        if (accept) begin
            state_d = in_mem ? MEM : OUT;
            cnt_d   = 3'(MEM_LAT - 1);
        end else if (retire) begin
            state_d = IDLE;
        end else if (state_q == MEM) begin
            state_d = cnt_q == '0 ? OUT : MEM;
            cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // wb_q holds the ALU result, doubling as the address until a load overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q  <= '0;
            wb_q     <= '0;
            wdata_q  <= '0;
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_q | (retire && op == 2'b11);
            if (accept) begin
                instr_q <= instr;
                wb_q    <= alu_result;
                wdata_q <= write_data;
                pc_q    <= pc_alu;
            end else if (mem_done && op == 2'b01 && sub == 2'b01) begin
                wb_q <= mem_q[addr];
            end
        end
    end

`ifdef MEM_RESET_CLEAR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[addr] <= wdata_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[addr] <= wdata_q;
    end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage flow control, loads/stores, jumps, stalls and halt.
module tb_mem_stage;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] instr, alu_result, write_data, pc_alu;
    logic       wb_en, redirect_valid, halted;
    logic [1:0] wb_reg;
    logic [7:0] wb_data, redirect_pc;
    int         checks = 0;
    int         failures = 0;

`ifdef MEM_RESET_CLEAR_EN
    localparam logic [7:0] CLR_FF = 8'h00;
    localparam logic [7:0] CLR_11 = 8'h00;
`else
    localparam logic [7:0] CLR_FF = 8'hFF;
    localparam logic [7:0] CLR_11 = 8'h11;
`endif

    mem_stage #(.DEPTH(256), .MEM_LAT(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .alu_result(alu_result), .write_data(write_data), .pc_alu(pc_alu),
        .out_valid(out_valid), .out_ready(out_ready), .wb_en(wb_en), .wb_reg(wb_reg),
        .wb_data(wb_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] i, input logic [7:0] a, input logic [7:0] w, input logic [7:0] p);
        in_valid = 1'b1; instr = i; alu_result = a; write_data = w; pc_alu = p;
        tick(1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; alu_result = '0; write_data = '0; pc_alu = '0;
        tick(2);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_redirect", redirect_valid, 0);
        rst = 1'b0;

        send(8'h04, 8'h2A, 8'h00, 8'h00);
        chk("add_ov", out_valid, 1);
        chk("add_wb_en", wb_en, 1);
        chk("add_wb_reg", wb_reg, 1);
        chk("add_wb_data", wb_data, 8'h2A);
        chk("add_redir", redirect_valid, 0);
        tick(1);
        chk("add_retired", out_valid, 0);

        send(8'h68, 8'h10, 8'h5C, 8'h00);
        chk("st_lat1", out_valid, 0);
        tick(1);
        chk("st_lat2", out_valid, 0);
        tick(1);
        chk("st_ov", out_valid, 1);
        chk("st_wb_en", wb_en, 0);
        send(8'h5C, 8'h10, 8'h00, 8'h00);
        chk("ld_lat1", out_valid, 0);
        tick(1);
        chk("ld_lat2", out_valid, 0);
        tick(1);
        chk("ld_ov", out_valid, 1);
        chk("ld_wb_en", wb_en, 1);
        chk("ld_wb_reg", wb_reg, 3);
        chk("ld_wb_data", wb_data, 8'h5C);
        tick(1);

        send(8'h85, 8'h00, 8'h00, 8'h05);
        chk("j_ov", out_valid, 1);
        chk("j_redir", redirect_valid, 1);
        chk("j_pc", redirect_pc, 8'h05);
        chk("j_wb_en", wb_en, 0);
        tick(1);

        out_ready = 1'b0;
        send(8'h44, 8'h07, 8'h00, 8'h00);
        in_valid = 1'b1; instr = 8'h08; alu_result = 8'h33;
        for (int k = 0; k < 4; k++) begin
            chk("stall_ov", out_valid, 1);
            chk("stall_wb_data", wb_data, 8'h07);
            chk("stall_wb_reg", wb_reg, 1);
            chk("stall_in_ready", in_ready, 0);
            tick(1);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1);
        tick(1);
        chk("b2b1_ov", out_valid, 1);
        chk("b2b1_wb_data", wb_data, 8'h33);
        chk("b2b1_wb_reg", wb_reg, 2);
        instr = 8'h0C; alu_result = 8'h44;
        tick(1);
        chk("b2b2_wb_data", wb_data, 8'h44);
        chk("b2b2_wb_reg", wb_reg, 3);
        in_valid = 1'b0;
        tick(1);
        chk("b2b_idle", out_valid, 0);

        send(8'hC0, 8'h00, 8'h00, 8'h00);
        in_valid = 1'b1; instr = 8'h04; alu_result = 8'h2A;
        chk("halt_pre", halted, 0);
        chk("halt_out_in_ready", in_ready, 0);
        tick(1);
        chk("halt_set", halted, 1);
        chk("halt_in_ready", in_ready, 0);
        chk("halt_no_accept", out_valid, 0);
        tick(1);
        chk("halt_still_idle", out_valid, 0);
        chk("halt_sticky", halted, 1);
        rst = 1'b1;
        #1;
        chk("halt_rst_cleared", halted, 0);
        chk("halt_rst_in_ready", in_ready, 1);
        in_valid = 1'b0;
        tick(1);
        rst = 1'b0;

        send(8'h60, 8'h20, 8'hFF, 8'h00);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        send(8'h54, 8'h20, 8'h00, 8'h00);
        tick(2);
        chk("clr_ld_ov", out_valid, 1);
        chk("clr_ld_data", wb_data, CLR_FF);
        tick(1);

        send(8'h60, 8'h30, 8'h11, 8'h00);
        tick(3);
        send(8'h60, 8'h30, 8'h99, 8'h00);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("abort_st_ov", out_valid, 0);
        send(8'h54, 8'h30, 8'h00, 8'h00);
        tick(2);
        chk("abort_ld_ov", out_valid, 1);
        chk("abort_ld_data", wb_data, CLR_11);
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
